// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port function-ROM arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int ROM_ADDR_W = 4;
    localparam int ROM_DATA_W = 5;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that was not granted last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_any,
    output logic winner
);

    always_comb begin
        gnt_any = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else begin
            winner = req1;
        end
    end

endmodule

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one combinational function ROM between two requesters.
// Define ROM_ACCESS_CNT_EN to add per-port saturating completion counters cnt0/cnt1.
module rom_access_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              valid0,
    output logic              valid1,
`ifdef ROM_ACCESS_CNT_EN
    output logic [7:0]        cnt0,
    output logic [7:0]        cnt1,
`endif
    output logic              busy
);

    state_e            state_q, state_d;
    logic              winner_q, winner_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              valid0_q, valid0_d;
    logic              valid1_q, valid1_d;
    logic              gnt_any;
    logic              pick;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .gnt_any    (gnt_any),
        .winner     (pick)
    );

    // The address is latched once in IDLE; later addrX changes cannot disturb the read.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        rom_addr_d   = rom_addr_q;
        rd_data_d    = rd_data_q;
        valid0_d     = 1'b0;
        valid1_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    winner_d   = pick;
                    rom_addr_d = (pick == PORT1) ? addr1 : addr0;
                    state_d    = READ;
                end
            end
            READ: begin
                state_d = RESP;
            end
            RESP: begin
                rd_data_d    = rom_data;
                valid0_d     = (winner_q == PORT0);
                valid1_d     = (winner_q == PORT1);
                last_grant_d = winner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            winner_q     <= PORT0;
            last_grant_q <= PORT1;
            rom_addr_q   <= '0;
            rd_data_q    <= '0;
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            rom_addr_q   <= rom_addr_d;
            rd_data_q    <= rd_data_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
        end
    end

`ifdef ROM_ACCESS_CNT_EN
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    // Counts advance together with the valid pulse they record and stick at 255.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (valid0_d && (cnt0_q != 8'hFF)) begin
            cnt0_d = cnt0_q + 8'd1;
        end
        if (valid1_d && (cnt1_q != 8'hFF)) begin
            cnt1_d = cnt1_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

    assign rom_addr = rom_addr_q;
    assign rd_data  = rd_data_q;
    assign valid0   = valid0_q;
    assign valid1   = valid1_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares one combinational function ROM (4-bit address, 5-bit data) between two requesters.
- Arbitration is round-robin. Each transaction uses a req/valid handshake; the read data returned is registered.
- Sits between the FUNCROM instance and two client FSMs, such as a RAM-loader and a lookup unit, in the lab datapath.

Parameters:
- ADDR_W, 4, ROM address width.
- DATA_W, 5, ROM data width.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 read request; held high until valid0.
- addr0  input  ADDR_W  port 0 address; stable while req0 is high.
- req1  input  1  port 1 read request; held high until valid1.
- addr1  input  ADDR_W  port 1 address; stable while req1 is high.
- rom_addr  output  ADDR_W  address driven to the ROM.
- rom_data  input  DATA_W  ROM output (combinational in rom_addr).
- rd_data  output  DATA_W  registered read data, shared by both ports.
- valid0  output  1  one-cycle pulse: rd_data belongs to port 0.
- valid1  output  1  one-cycle pulse: rd_data belongs to port 1.
- busy  output  1  high while a transaction is in flight.

Behaviour:
- Clock and reset are decided: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: rom_addr=0, rd_data=0, valid0=0, valid1=0, busy=0, state=IDLE, last_grant=1 (so port 0 wins the first tie).
- FSM states and transitions:
  - IDLE: if any req is high, pick a winner and latch the winner id and its address into rom_addr. Go to READ.
  - READ: rom_addr stays stable; the ROM settles. Go to RESP.
  - RESP: register rom_data into rd_data; pulse valid of the winner; set last_grant=winner. Go to IDLE.
- Latency: req sampled high at edge N -> valid pulses in the cycle after edge N+2 (3 cycles request-to-data).
  - Back-to-back throughput is one transaction per 3 cycles.
- Arbitration rules:
  - Only one request high: that port wins.
  - Both high in IDLE: the port not equal to last_grant wins.
  - The loser stays pending and is served in the immediately following transaction if its req is still high.
- Handshake rules:
  - The requester deasserts req in the cycle valid is seen, or keeps it high to issue a new read.
  - A req still high in the IDLE cycle after valid counts as a new request.
  - The arbiter does not re-sample addrX after the IDLE latch; address changes mid-transaction are ignored.
  - A req dropped before valid does not abort the transaction; valid still pulses.
- Output holds:
  - rd_data holds its value until the next RESP; it never returns to 0 except on reset.
  - rom_addr holds its last value in IDLE when there is no request.
- busy is high in READ and RESP and low in IDLE.
- valid0 and valid1 are never high simultaneously.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous); no valid pulse is produced for the aborted read.

Optional Feature:
- Macro: ROM_ACCESS_CNT_EN.
- When defined:
  - Adds outputs cnt0 and cnt1, each 8 bits: per-port saturating counts of completed transactions.
  - Each count increments on its port's valid pulse and saturates at 255.
  - Both reset to 0.
- When undefined: the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package rom_arb_pkg holds:
  - state enum IDLE/READ/RESP, 2 bits;
  - localparams ROM_ADDR_W=4, ROM_DATA_W=5;
  - port id constants PORT0=0, PORT1=1.
- One sub-module, rr_pick2: a combinational two-way round-robin picker.
  - Inputs: req0, req1, last_grant. Outputs: gnt_any, winner.
  - Reused by future shared-RAM arbiters.

Test Plan:
- Reset, then req0=1, addr0=4'b0001 -> valid0 pulses 3 cycles later with rd_data=5'b00010; valid1=0 throughout.
- req1=1, addr1=4'b1111 alone -> valid1 pulse with rd_data=5'b11111; busy high for exactly 2 cycles.
- req0 and req1 both raised in the same cycle after reset, addr0=0, addr1=4'b0010:
  - port 0 is served first (rd_data=0);
  - port 1 is served in the next transaction (rd_data=5'b00100), 3 cycles later.
- Both reqs held high continuously -> grants alternate 0,1,0,1 over 4 transactions; no valid overlap.
- rst_n pulled low during READ -> all outputs 0 the same instant; no valid after release.
- Change addr0 from 0001 to 0010 during READ -> rd_data=5'b00010 (the original address); with ROM_ACCESS_CNT_EN defined, cnt0 increments by 1.
